// File: rtl/baud_gen_frac.sv
// Fractional baud generator: os_tick every div_int + div_frac/2^FRAC_W clocks, baud_tick every OVERSAMPLE os_ticks.
// All outputs registered; divisor updates are shadowed and applied only on period boundaries.
module baud_gen_frac #(
   parameter int DIV_W      = 16,
   parameter int FRAC_W     = 4,
   parameter int OVERSAMPLE = 16,
   parameter int RESET_DIV  = 651,
   parameter int RESET_FRAC = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic [DIV_W-1:0]  div_int,
   input  logic [FRAC_W-1:0] div_frac,
   input  logic              div_load,
   input  logic              sync_clr,
   output logic              os_tick,
   output logic              baud_tick,
   output logic              cfg_err
);

   localparam int                OS_W     = $clog2(OVERSAMPLE);
   localparam logic [OS_W-1:0]   OS_LAST  = OS_W'(OVERSAMPLE - 1);
   localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(RESET_DIV);
   localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(RESET_FRAC);
   localparam logic              RST_ERR  = (RESET_DIV < 2);

   logic [DIV_W-1:0]  act_int_q, act_int_d;
   logic [FRAC_W-1:0] act_frac_q, act_frac_d;
   logic [DIV_W-1:0]  shd_int_q, shd_int_d;
   logic [FRAC_W-1:0] shd_frac_q, shd_frac_d;
   logic              pend_q, pend_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
   logic [OS_W-1:0]   os_cnt_q, os_cnt_d;
   logic              os_tick_q, os_tick_d;
   logic              baud_tick_q, baud_tick_d;
   logic              cfg_err_q, cfg_err_d;

   logic [FRAC_W:0]   frac_sum;
   logic [DIV_W:0]    last_cnt;
   logic              act_bad;
   logic              period_end;
   logic              apply_new;
   logic              apply_shd;

   // The fractional carry stretches this period by one clock.
   assign frac_sum = {1'b0, frac_acc_q} + {1'b0, act_frac_q};
   assign last_cnt = {1'b0, act_int_q} + {{DIV_W{1'b0}}, frac_sum[FRAC_W]} - {{DIV_W{1'b0}}, 1'b1};
   assign act_bad  = (act_int_q < DIV_W'(2));

   // >= rather than == so a smaller divisor loaded while frozen still ends the period.
   assign period_end = en && !sync_clr && !act_bad && ({1'b0, cnt_q} >= last_cnt);

   assign apply_new = div_load && (sync_clr || !en);
   assign apply_shd = pend_q && (sync_clr || period_end || act_bad);

   always_comb begin
      act_int_d   = act_int_q;
      act_frac_d  = act_frac_q;
      shd_int_d   = shd_int_q;
      shd_frac_d  = shd_frac_q;
      pend_d      = pend_q;
      cnt_d       = cnt_q;
      frac_acc_d  = frac_acc_q;
      os_cnt_d    = os_cnt_q;
      os_tick_d   = 1'b0;
      baud_tick_d = 1'b0;
      cfg_err_d   = act_bad;

      if (div_load) begin
         shd_int_d  = div_int;
         shd_frac_d = div_frac;
      end

      // A load in the same cycle as a shadow apply stays pending for the next boundary.
      if (apply_new) begin
         act_int_d  = div_int;
         act_frac_d = div_frac;
         pend_d     = 1'b0;
      end else if (apply_shd) begin
         act_int_d  = shd_int_q;
         act_frac_d = shd_frac_q;
         pend_d     = div_load;
      end else if (div_load) begin
         pend_d = 1'b1;
      end

      if (sync_clr) begin
         cnt_d      = '0;
         frac_acc_d = '0;
         os_cnt_d   = '0;
      end else if (en) begin
         if (act_bad) begin
            cnt_d = '0;
         end else if (period_end) begin
            cnt_d       = '0;
            frac_acc_d  = frac_sum[FRAC_W-1:0];
            os_cnt_d    = (os_cnt_q == OS_LAST) ? '0 : os_cnt_q + OS_W'(1);
            os_tick_d   = 1'b1;
            baud_tick_d = (os_cnt_q == OS_LAST);
         end else begin
            cnt_d = cnt_q + DIV_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         act_int_q   <= RST_INT;
         act_frac_q  <= RST_FRAC;
         shd_int_q   <= RST_INT;
         shd_frac_q  <= RST_FRAC;
         pend_q      <= 1'b0;
         cnt_q       <= '0;
         frac_acc_q  <= '0;
         os_cnt_q    <= '0;
         os_tick_q   <= 1'b0;
         baud_tick_q <= 1'b0;
         cfg_err_q   <= RST_ERR;
      end else begin
         act_int_q   <= act_int_d;
         act_frac_q  <= act_frac_d;
         shd_int_q   <= shd_int_d;
         shd_frac_q  <= shd_frac_d;
         pend_q      <= pend_d;
         cnt_q       <= cnt_d;
         frac_acc_q  <= frac_acc_d;
         os_cnt_q    <= os_cnt_d;
         os_tick_q   <= os_tick_d;
         baud_tick_q <= baud_tick_d;
         cfg_err_q   <= cfg_err_d;
      end
   end

   assign os_tick   = os_tick_q;
   assign baud_tick = baud_tick_q;
   assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Bench for baud_gen_frac: expected tick times/baud flags queued from a divisor-arithmetic model, popped as ticks appear.
module tb_baud_gen_frac;

   logic        clk      = 1'b0;
   logic        rst      = 1'b1;
   logic        en       = 1'b0;
   logic [15:0] div_int  = '0;
   logic [3:0]  div_frac = '0;
   logic        div_load = 1'b0;
   logic        sync_clr = 1'b0;
   logic        os_tick;
   logic        baud_tick;
   logic        cfg_err;

   int cyc       = 0;
   int total     = 0;
   int bad       = 0;
   int last_tick = 0;
   int m_t       = 0;
   int m_acc     = 0;
   int m_k       = 0;

   typedef struct {
      int t;
      bit baud;
   } tick_t;

   typedef struct {
      int di;
      int df;
      int n;
      int span;
   } vec_t;

   tick_t exp_q[$];

   baud_gen_frac dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .div_int   (div_int),
      .div_frac  (div_frac),
      .div_load  (div_load),
      .sync_clr  (sync_clr),
      .os_tick   (os_tick),
      .baud_tick (baud_tick),
      .cfg_err   (cfg_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int got, input int want);
      total++;
      if (got != want) begin
         bad++;
         $display("FAIL %s got=%0d want=%0d", name, got, want);
      end
   endtask

   task automatic wait_until(input int t);
      while (cyc < t) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic model_clear(input int t0);
      m_t   = t0;
      m_acc = 0;
      m_k   = 0;
   endtask

   // Periods of di or di+1 clocks, +1 whenever the 4-bit fraction accumulator overflows.
   task automatic model_push(input int di, input int df, input int n);
      tick_t e;
      for (int i = 0; i < n; i++) begin
         m_t   += di + ((m_acc + df >= 16) ? 1 : 0);
         m_acc  = (m_acc + df) % 16;
         m_k++;
         e.t    = m_t;
         e.baud = (m_k % 16 == 0);
         exp_q.push_back(e);
      end
   endtask

   task automatic start_cfg(input int di, input int df, output int t0);
      en       = 1'b0;
      div_int  = 16'(di);
      div_frac = 4'(df);
      div_load = 1'b1;
      sync_clr = 1'b1;
      @(posedge clk);
      #1;
      t0       = cyc;
      div_load = 1'b0;
      sync_clr = 1'b0;
      en       = 1'b1;
      model_clear(t0);
   endtask

   task automatic pulse_load(input int di, input int t);
      wait_until(t - 1);
      div_int  = 16'(di);
      div_frac = 4'(0);
      div_load = 1'b1;
      wait_until(t);
      div_load = 1'b0;
   endtask

   task automatic finish_run(input string name);
      wait_until(m_t);
      en = 1'b0;
      @(posedge clk);
      #1;
      check(name, exp_q.size(), 0);
   endtask

   task automatic monitor();
      tick_t e;
      forever begin
         @(negedge clk);
         if (os_tick) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++;
               $display("FAIL unexpected_os_tick cyc=%0d got=1 want=0", cyc);
            end else begin
               e = exp_q.pop_front();
               last_tick = cyc;
               if (e.t != cyc || e.baud != baud_tick) begin
                  bad++;
                  $display("FAIL tick got cyc=%0d baud=%0d want cyc=%0d baud=%0d",
                           cyc, baud_tick, e.t, e.baud);
               end
            end
         end else if (baud_tick) begin
            total++;
            bad++;
            $display("FAIL baud_without_os cyc=%0d got=1 want=0", cyc);
         end
      end
   endtask

   initial begin
      vec_t vecs[6];
      int   c0;
      vecs[0] = '{6, 0, 1000, 6000};
      vecs[1] = '{6, 8, 32, 208};
      vecs[2] = '{5, 0, 20, 100};
      vecs[3] = '{7, 3, 16, 115};
      vecs[4] = '{2, 15, 16, 47};
      vecs[5] = '{3, 1, 16, 49};

      fork
         monitor();
      join_none

      // Reset values, then the reset divisor 651 + 1/16 running from release.
      #2 rst = 1'b0;
      en = 1'b1;
      #10;
      check("rst_os_tick", int'(os_tick), 0);
      check("rst_baud_tick", int'(baud_tick), 0);
      check("rst_cfg_err", int'(cfg_err), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      c0  = cyc;
      model_clear(c0);
      model_push(651, 1, 16);
      wait_until(m_t);
      #1;
      check("tick_before_rst", int'(os_tick), 1);
      check("baud_before_rst", int'(baud_tick), 1);
      #5 rst = 1'b0;
      #1;
      check("async_rst_os_tick", int'(os_tick), 0);
      check("async_rst_baud_tick", int'(baud_tick), 0);
      check("rst_span", last_tick - c0, 10417);
      check("rst_q_empty", exp_q.size(), 0);
      en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b1;

      for (int i = 0; i < 6; i++) begin
         start_cfg(vecs[i].di, vecs[i].df, c0);
         model_push(vecs[i].di, vecs[i].df, vecs[i].n);
         finish_run($sformatf("vec%0d_q_empty", i));
         check($sformatf("vec%0d_span", i), last_tick - c0, vecs[i].span);
         check($sformatf("vec%0d_cfg_err", i), int'(cfg_err), 0);
      end

      // Shadowed loads: current period keeps its length, last load before the boundary wins.
      start_cfg(6, 0, c0);
      model_push(6, 0, 2);
      model_push(10, 0, 2);
      model_push(12, 0, 2);
      pulse_load(10, c0 + 8);
      pulse_load(8, c0 + 24);
      pulse_load(12, c0 + 27);
      finish_run("load_q_empty");
      check("load_span", last_tick - c0, 56);

      // sync_clr on a period-end edge with os_cnt=9 and a pending load of 4.
      start_cfg(6, 0, c0);
      model_push(6, 0, 9);
      model_clear(c0 + 60);
      model_push(4, 0, 16);
      pulse_load(4, c0 + 58);
      wait_until(c0 + 59);
      sync_clr = 1'b1;
      wait_until(c0 + 60);
      sync_clr = 1'b0;
      finish_run("clr_q_empty");
      check("clr_span", last_tick - c0, 124);

      // Invalid divisor, then recovery with an en freeze in the second period.
      start_cfg(1, 0, c0);
      check("cfg_err_lag_rise", int'(cfg_err), 0);
      wait_until(c0 + 1);
      check("cfg_err_rise", int'(cfg_err), 1);
      wait_until(c0 + 100);
      check("cfg_err_hold", int'(cfg_err), 1);
      start_cfg(5, 0, c0);
      model_push(5, 0, 1);
      m_t += 5;
      model_push(5, 0, 3);
      check("cfg_err_lag_fall", int'(cfg_err), 1);
      wait_until(c0 + 1);
      check("cfg_err_fall", int'(cfg_err), 0);
      wait_until(c0 + 7);
      en = 1'b0;
      wait_until(c0 + 12);
      en = 1'b1;
      finish_run("cfg_q_empty");
      check("cfg_span", last_tick - c0, 25);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
